// File: rtl/cam_capture_packer.sv
// Camera capture stage: synchronises the OV5642 byte bus, reduces RGB565 to RGB332,
// packs two pixels per word and queues {address, data} entries for a req/ack write port.
module cam_capture_packer #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [22:0] BASE_ADDR  = 23'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cam_pclk,
  input  logic        cam_href_i,
  input  logic        cam_vsync_i,
  input  logic [7:0]  cam_din,
  input  logic        enable,
  output logic        wr_req,
  output logic [22:0] wr_addr,
  output logic [15:0] wr_data,
  input  logic        wr_ack,
  output logic        frame_done,
  output logic        cam_err_l
);

  localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);
  localparam logic [22:0] FrameWords = 23'(H_ACTIVE * V_ACTIVE / 2);
  localparam logic [22:0] LastAddr   = BASE_ADDR + FrameWords - 23'd1;

  typedef enum logic [1:0] {StIdle, StCapture, StDone} state_e;

  // Synchronisers; pclk and vsync carry a third stage for edge detection.
  logic [2:0] pclk_q, vsync_q;
  logic [1:0] href_q;
  logic [7:0] din1_q, din2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pclk_q  <= '0;
      vsync_q <= '0;
      href_q  <= '0;
      din1_q  <= '0;
      din2_q  <= '0;
    end else begin
      pclk_q  <= {pclk_q[1:0], cam_pclk};
      vsync_q <= {vsync_q[1:0], cam_vsync_i};
      href_q  <= {href_q[0], cam_href_i};
      din1_q  <= cam_din;
      din2_q  <= din1_q;
    end
  end

  logic pclk_edge, vs_edge, href_s;
  assign pclk_edge = pclk_q[1] & ~pclk_q[2];
  assign vs_edge   = vsync_q[1] & ~vsync_q[2];
  assign href_s    = href_q[1];

  // Capture / packing state
  state_e      state_q, state_d;
  logic        frame_start;
  logic        bphase_q, bphase_d, pphase_q, pphase_d;
  logic [7:0]  hi_q, hi_d, even_q, even_d;
  logic [22:0] widx_q, widx_d;
  logic        push_q, push_d;
  logic [38:0] push_word_q, push_word_d;
  logic [7:0]  pix;
  logic        byte_ok;

  assign pix     = {hi_q[7:5], hi_q[2:0], din2_q[4:3]};
  assign byte_ok = pclk_edge & href_s & (state_q == StCapture);

  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    case (state_q)
      StIdle: begin
        if (vs_edge && enable) begin
          state_d     = StCapture;
          frame_start = 1'b1;
        end
      end
      StCapture, StDone: begin
        if (vs_edge) begin
          if (enable) begin
            state_d     = StCapture;
            frame_start = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else if (push_d && (widx_q == FrameWords - 23'd1)) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bphase_d    = bphase_q;
    pphase_d    = pphase_q;
    hi_d        = hi_q;
    even_d      = even_q;
    widx_d      = widx_q;
    push_d      = 1'b0;
    push_word_d = push_word_q;
    // A vsync edge wins over a coincident byte edge; that byte is lost.
    if (vs_edge) begin
      if (frame_start) begin
        bphase_d = 1'b0;
        pphase_d = 1'b0;
        widx_d   = '0;
      end
    end else if (!href_s) begin
      bphase_d = 1'b0;
      pphase_d = 1'b0;
    end else if (byte_ok) begin
      if (!bphase_q) begin
        hi_d     = din2_q;
        bphase_d = 1'b1;
      end else begin
        bphase_d = 1'b0;
        if (!pphase_q) begin
          even_d   = pix;
          pphase_d = 1'b1;
        end else begin
          pphase_d    = 1'b0;
          push_d      = 1'b1;
          push_word_d = {BASE_ADDR + widx_q, even_q, pix};
          widx_d      = widx_q + 23'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      bphase_q    <= 1'b0;
      pphase_q    <= 1'b0;
      hi_q        <= '0;
      even_q      <= '0;
      widx_q      <= '0;
      push_q      <= 1'b0;
      push_word_q <= '0;
    end else begin
      state_q     <= state_d;
      bphase_q    <= bphase_d;
      pphase_q    <= pphase_d;
      hi_q        <= hi_d;
      even_q      <= even_d;
      widx_q      <= widx_d;
      push_q      <= push_d;
      push_word_q <= push_word_d;
    end
  end

  // Word FIFO; count carries one extra bit so its MSB alone flags full.
  logic [38:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0]   count_q, count_d;
  logic            empty, full, pop, do_write, drop;
  logic [38:0]     head;
  logic            err_q, done_q;

  assign empty    = (count_q == '0);
  assign full     = count_q[PtrW];
  assign pop      = wr_ack & ~empty;
  assign do_write = push_q & (~full | pop);
  assign drop     = push_q & full & ~pop;
  assign head     = mem_q[rptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_write, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_write) mem_q[wptr_q] <= push_word_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (do_write) wptr_q <= wptr_q + 1'b1;
      if (pop)      rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
      if (drop) err_q <= 1'b1;
      done_q  <= pop & (head[38:16] == LastAddr);
    end
  end

  assign wr_req     = ~empty;
  assign wr_addr    = empty ? '0 : head[38:16];
  assign wr_data    = empty ? '0 : head[15:0];
  assign frame_done = done_q;
  assign cam_err_l  = ~err_q;

endmodule

// File: tb/tb_cam_capture_packer.sv
// Directed bench with a transaction-level model: expected words live in a queue and
// every DUT handshake is checked against its head.
module tb_cam_capture_packer;

  localparam int unsigned H = 4, V = 4, D = 4;
  localparam int unsigned WORDS = H * V / 2;

  logic clk = 1'b0;
  logic rst, pclk, href, vsync, enable, wr_ack;
  logic [7:0]  din;
  logic        wr_req, frame_done, cam_err_l;
  logic [22:0] wr_addr;
  logic [15:0] wr_data;

  always #5 clk = ~clk;

  cam_capture_packer #(
    .H_ACTIVE  (H),
    .V_ACTIVE  (V),
    .FIFO_DEPTH(D),
    .BASE_ADDR (23'h0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cam_pclk   (pclk),
    .cam_href_i (href),
    .cam_vsync_i(vsync),
    .cam_din    (din),
    .enable     (enable),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .frame_done (frame_done),
    .cam_err_l  (cam_err_l)
  );

  int checks = 0, errors = 0;
  logic [38:0] exp_q[$];
  bit m_cap, m_bph, m_pph, m_err, m_tol, fd_exp;
  int m_widx, fd_count, pop_count;
  logic [7:0] m_hi, m_even;
  logic [38:0] hd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] rgb332(input logic [15:0] p);
    return {p[15:13], p[10:8], p[4:3]};
  endfunction

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] px;
    if (!m_cap || m_widx >= int'(WORDS)) return;
    if (!m_bph) begin
      m_hi  = b;
      m_bph = 1;
    end else begin
      m_bph = 0;
      px = rgb332({m_hi, b});
      if (!m_pph) begin
        m_even = px;
        m_pph  = 1;
      end else begin
        m_pph = 0;
        if (exp_q.size() < D + (m_tol ? 1 : 0)) exp_q.push_back({23'(m_widx), m_even, px});
        else m_err = 1;
        m_widx++;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    @(negedge clk);
    din  = b;
    href = 1'b1;
    repeat (2) @(negedge clk);
    pclk = 1'b1;
    repeat (2) @(negedge clk);
    pclk = 1'b0;
  endtask

  task automatic send_pixel(input logic [15:0] p);
    send_byte(p[15:8]);
    send_byte(p[7:0]);
  endtask

  task automatic href_gap();
    m_bph = 0;
    m_pph = 0;
    @(negedge clk);
    href = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic vsync_pulse();
    m_cap = enable;
    m_widx = 0;
    m_bph = 0;
    m_pph = 0;
    @(negedge clk);
    href  = 1'b0;
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    vsync = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  task automatic drain();
    repeat (6) @(negedge clk);
    wr_ack = 1'b1;
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'(0));
    wr_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("drain_wr_req", 64'(wr_req), 64'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    pclk = 1'b0;
    href = 1'b0;
    vsync = 1'b0;
    exp_q.delete();
    m_cap = 0;
    m_err = 0;
    m_bph = 0;
    m_pph = 0;
    #1;
    check("rst_wr_req", 64'(wr_req), 64'(0));
    check("rst_wr_addr", 64'(wr_addr), 64'(0));
    check("rst_wr_data", 64'(wr_data), 64'(0));
    check("rst_err_l", 64'(cam_err_l), 64'(1));
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_head(input string name, input logic [22:0] a, input logic [15:0] d);
    check({name, "_qsize"}, 64'(exp_q.size() > 0), 64'(1));
    check(name, 64'(exp_q.size() > 0 ? exp_q[0] : 39'h0), 64'({a, d}));
  endtask

  // Per-cycle compare against the model, sampled mid low phase.
  initial begin
    fd_exp = 0;
    forever begin
      @(negedge clk);
      #2;
      check("frame_done", 64'(frame_done), 64'(fd_exp));
      if (frame_done) fd_count++;
      fd_exp = 0;
      if (!rst) begin
        check("wr_req_without_model_entry", 64'(wr_req && exp_q.size() == 0), 64'(0));
        if (wr_req && wr_ack && exp_q.size() != 0) begin
          hd = exp_q.pop_front();
          check("wr_addr", 64'(wr_addr), 64'(hd[38:16]));
          check("wr_data", 64'(wr_data), 64'(hd[15:0]));
          pop_count++;
          fd_exp = (hd[38:16] == 23'(WORDS - 1));
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc;
    logic [15:0] p;
    rst = 1'b1; pclk = 1'b0; href = 1'b0; vsync = 1'b0; din = '0;
    enable = 1'b1; wr_ack = 1'b0; m_tol = 0; fd_count = 0; pop_count = 0;
    repeat (3) @(negedge clk);
    check("init_wr_req", 64'(wr_req), 64'(0));
    check("init_wr_addr", 64'(wr_addr), 64'(0));
    check("init_wr_data", 64'(wr_data), 64'(0));
    check("init_frame_done", 64'(frame_done), 64'(0));
    check("init_err_l", 64'(cam_err_l), 64'(1));
    rst = 1'b0;

    // Single pixel pair and push latency
    vsync_pulse();
    send_byte(8'hF8); send_byte(8'h00); send_byte(8'h07); send_byte(8'hE0);
    check_head("pair_model", 23'h0, 16'hE01C);
    @(negedge clk); #2;
    check("pair_req_cycle3", 64'(wr_req), 64'(0));
    @(negedge clk); #2;
    check("pair_req_cycle4", 64'(wr_req), 64'(1));
    check("pair_addr", 64'(wr_addr), 64'(0));
    check("pair_data", 64'(wr_data), 64'(16'hE01C));
    drain();

    // Full frame with continuous acks, then bytes after the frame is complete
    vsync_pulse();
    fd_count = 0;
    pc = pop_count;
    wr_ack = 1'b1;
    for (int l = 0; l < int'(V); l++) begin
      for (int x = 0; x < int'(H); x++) begin
        p = 16'((l * 4 + x) * 4951) ^ 16'hA5C3;
        send_pixel(p);
      end
      href_gap();
    end
    settle();
    send_pixel(16'h1234); send_pixel(16'h5678);
    settle();
    check("frame_extra_no_req", 64'(wr_req), 64'(0));
    check("frame_pops", 64'(pop_count - pc), 64'(WORDS));
    check("frame_done_count", 64'(fd_count), 64'(1));
    wr_ack = 1'b0;

    // Overflow: 4 entries held, 5th word dropped, indexing continues
    vsync_pulse();
    for (int i = 0; i < 8; i++) send_pixel(16'(i * 16'h0841 + 16'h1111));
    settle();
    check("ovf_err_before", 64'(cam_err_l), 64'(1));
    send_pixel(16'hFFFF); send_pixel(16'h0000);
    settle();
    check("ovf_model_err", 64'(m_err), 64'(1));
    check("ovf_err_after", 64'(cam_err_l), 64'(0));
    drain();
    send_pixel(16'hF800); send_pixel(16'h001F);
    check_head("ovf_next_word", 23'd5, 16'hE003);
    drain();

    // Push and pop coincide while full
    do_reset();
    vsync_pulse();
    for (int i = 0; i < 8; i++) send_pixel(16'(i * 16'h1083));
    settle();
    m_tol = 1;
    send_pixel(16'h07E0); send_pixel(16'hF81F);
    @(negedge clk);
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
    m_tol = 0;
    settle();
    check("simul_err_l", 64'(cam_err_l), 64'(1));
    check("simul_model_size", 64'(exp_q.size()), 64'(4));
    pc = pop_count;
    drain();
    check("simul_remaining", 64'(pop_count - pc), 64'(4));

    // Orphan byte across an href gap is discarded
    vsync_pulse();
    send_byte(8'hAB);
    href_gap();
    send_pixel(16'hFFFF); send_pixel(16'h001F);
    check_head("gap_model", 23'h0, 16'hFF03);
    drain();

    // Capture disabled at frame start
    enable = 1'b0;
    vsync_pulse();
    for (int i = 0; i < 4; i++) send_pixel(16'hABCD);
    settle();
    check("disabled_no_req", 64'(wr_req), 64'(0));
    enable = 1'b1;

    // Reset mid-frame with 3 words queued
    vsync_pulse();
    for (int i = 0; i < 6; i++) send_pixel(16'(16'h2345 + i));
    settle();
    check("midrst_queued", 64'(wr_req), 64'(1));
    do_reset();
    vsync_pulse();
    send_pixel(16'h8410); send_pixel(16'h4208);
    check_head("midrst_restart", 23'h0, {rgb332(16'h8410), rgb332(16'h4208)});
    drain();

    settle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
